// File: rtl/cache_lru_ctrl.sv
// cache_lru_ctrl: request sequencer for an N-way set-associative cache.
// Takes one CPU request at a time through lookup, optional dirty-victim
// write-back, line fill, replay and LRU age update, and drives the memory-side
// request/acknowledge handshake.
//
// Build option: define CACHE_WB_EN for a write-back cache. Dirty victims are
// then evicted before the fill, and write hits complete in UPDATE. Without it
// the cache is write-through: the dirty flags are ignored, and every write goes
// through WT and waits for mem_ack before it completes.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request; captures opcode/address/data on handshake
// LOOKUP | array access; samples hit result, ages and dirty flags
// EVICT  | writes the dirty victim back to memory, waits for mem_ack
// FILL   | fetches the line into the victim way, waits for mem_ack
// REPLAY | re-issues the array read/write into the freshly filled way
// UPDATE | one-cycle LRU age update of the selected way
// WT     | write-through of the write to memory, waits for mem_ack

module cache_lru_ctrl #(
   parameter int WAYS   = 4,
   parameter int AGE_W  = $clog2(WAYS),
   parameter int ADDR_W = 32,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_opcode,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   input  logic                  hit_miss,
   input  logic [WAYS-1:0]       hit_miss_set,
   input  logic [WAYS*AGE_W-1:0] ages,
   input  logic [WAYS-1:0]       dirty,
   output logic [ADDR_W-1:0]     address_word,
   output logic [DATA_W-1:0]     write_data,
   output logic                  try_read,
   output logic                  try_write,
   output logic [WAYS-1:0]       reset_age,
   output logic [WAYS-1:0]       increment_age,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [WAYS-1:0]       mem_way,
   input  logic                  mem_ack
);

   localparam int IDX_W = $clog2(WAYS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_EVICT  = 3'd2,
      S_FILL   = 3'd3,
      S_REPLAY = 3'd4,
      S_UPDATE = 3'd5,
      S_WT     = 3'd6
   } state_t;

   state_t                 state_q, state_d;
   logic                   op_q, op_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [IDX_W-1:0]       way_idx_q, way_idx_d;
   logic [WAYS*AGE_W-1:0]  ages_q, ages_d;

   logic [IDX_W-1:0]       hit_idx;
   logic [IDX_W-1:0]       vic_idx;
   logic [AGE_W-1:0]       vic_age;
   logic [AGE_W-1:0]       way_age;
   logic [WAYS-1:0]        way_oh;

`ifndef CACHE_WB_EN
   // A write-through cache never evicts, so the dirty flags are not consumed.
   logic unused_dirty;
   assign unused_dirty = ^dirty;
`endif

   // Hitting way: lowest set bit of the hit vector.
   always_comb begin
      hit_idx = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (hit_miss_set[i]) hit_idx = IDX_W'(i);
      end
   end

   // Victim: lowest-index way holding the maximum age (strict compare keeps the first).
   always_comb begin
      vic_idx = '0;
      vic_age = ages[AGE_W-1:0];
      for (int i = 1; i < WAYS; i++) begin
         if (ages[i*AGE_W +: AGE_W] > vic_age) begin
            vic_idx = IDX_W'(i);
            vic_age = ages[i*AGE_W +: AGE_W];
         end
      end
   end

   // Age of the selected way in the sampled age snapshot, plus its one-hot form.
   always_comb begin
      way_age = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (IDX_W'(i) == way_idx_q) way_age = ages_q[i*AGE_W +: AGE_W];
      end
      way_oh = WAYS'(1) << way_idx_q;
   end

   // Next-state and capture logic.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      way_idx_d = way_idx_q;
      ages_d    = ages_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = req_opcode;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            ages_d = ages;
            if (hit_miss) begin
               way_idx_d = hit_idx;
               state_d   = S_UPDATE;
            end else begin
               way_idx_d = vic_idx;
`ifdef CACHE_WB_EN
               state_d   = dirty[vic_idx] ? S_EVICT : S_FILL;
`else
               state_d   = S_FILL;
`endif
            end
         end
         S_EVICT: begin
            if (mem_ack) state_d = S_FILL;
         end
         S_FILL: begin
            if (mem_ack) state_d = S_REPLAY;
         end
         S_REPLAY: begin
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
`ifdef CACHE_WB_EN
            state_d = S_IDLE;
`else
            state_d = op_q ? S_WT : S_IDLE;
`endif
         end
         S_WT: begin
            if (mem_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and captured request registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= S_IDLE;
         op_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         way_idx_q <= '0;
         ages_q    <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         way_idx_q <= way_idx_d;
         ages_q    <= ages_d;
      end
   end

   // Output decode from state and captured registers; only the WT response looks at mem_ack.
   always_comb begin
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      try_read      = 1'b0;
      try_write     = 1'b0;
      reset_age     = '0;
      increment_age = '0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_way       = '0;
      case (state_q)
         S_IDLE: req_ready = 1'b1;
         S_LOOKUP, S_REPLAY: begin
            try_read  = ~op_q;
            try_write = op_q;
         end
         S_EVICT: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            mem_way = way_oh;
         end
         S_FILL: begin
            mem_req = 1'b1;
            mem_way = way_oh;
         end
         S_UPDATE: begin
            reset_age = way_oh;
            for (int i = 0; i < WAYS; i++) begin
               increment_age[i] = (ages_q[i*AGE_W +: AGE_W] < way_age);
            end
`ifdef CACHE_WB_EN
            resp_valid = 1'b1;
`else
            resp_valid = ~op_q;
`endif
         end
         S_WT: begin
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            mem_way    = way_oh;
            resp_valid = mem_ack;
         end
         default: ;
      endcase
   end

   assign address_word = addr_q;
   assign write_data   = wdata_q;

endmodule

// File: tb/tb_cache_lru_ctrl.sv
// Directed bench for cache_lru_ctrl (WAYS=4). Inputs change 1 time unit after
// the rising edge, and outputs are sampled at that same point.
`timescale 1ns/1ps
module tb_cache_lru_ctrl;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        req_valid, req_ready, req_opcode;
   logic [31:0] req_addr;
   logic [7:0]  req_wdata;
   logic        resp_valid;
   logic        hit_miss;
   logic [3:0]  hit_miss_set;
   logic [7:0]  ages;
   logic [3:0]  dirty;
   logic [31:0] address_word;
   logic [7:0]  write_data;
   logic        try_read, try_write;
   logic [3:0]  reset_age, increment_age;
   logic        mem_req, mem_we;
   logic [3:0]  mem_way;
   logic        mem_ack;

   int vec_cnt = 0;
   int err_cnt = 0;

   cache_lru_ctrl #(.WAYS(4), .ADDR_W(32), .DATA_W(8)) dut (
      .clk(clk), .rst_b(rst_b),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .hit_miss(hit_miss), .hit_miss_set(hit_miss_set), .ages(ages), .dirty(dirty),
      .address_word(address_word), .write_data(write_data),
      .try_read(try_read), .try_write(try_write),
      .reset_age(reset_age), .increment_age(increment_age),
      .mem_req(mem_req), .mem_we(mem_we), .mem_way(mem_way), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hand one request over in IDLE; returns with the block in LOOKUP.
   task automatic issue(input logic op, input logic [31:0] addr, input logic [7:0] wd);
      req_valid  = 1'b1;
      req_opcode = op;
      req_addr   = addr;
      req_wdata  = wd;
      tick();
      req_valid  = 1'b0;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 8'h00;
   endtask

   task automatic test_reset();
      rst_b = 1'b0; req_valid = 1'b0; req_opcode = 1'b0; req_addr = '0; req_wdata = '0;
      hit_miss = 1'b0; hit_miss_set = '0; ages = '0; dirty = '0; mem_ack = 1'b0;
      #12;
      vec_cnt++;
      if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_ready got %b exp 1", req_ready); end
      vec_cnt++;
      if ({mem_req, mem_we, mem_way, try_read, try_write, resp_valid} !== 9'b0) begin
         err_cnt++; $display("FAIL rst_strobes got %b exp 0", {mem_req, mem_we, mem_way, try_read, try_write, resp_valid});
      end
      vec_cnt++;
      if ({address_word, write_data, reset_age, increment_age} !== 48'h0) begin
         err_cnt++; $display("FAIL rst_regs got %h exp 0", {address_word, write_data, reset_age, increment_age});
      end
      @(negedge clk); rst_b = 1'b1;
      tick();
   endtask

   task automatic test_read_hit();
      issue(1'b0, 32'h0000_1234, 8'h00);
      vec_cnt++;
      if ({try_read, try_write, req_ready} !== 3'b100) begin err_cnt++; $display("FAIL hit_lookup_strobe got %b exp 100", {try_read, try_write, req_ready}); end
      vec_cnt++;
      if (address_word !== 32'h0000_1234) begin err_cnt++; $display("FAIL hit_addr got %h exp 00001234", address_word); end
      hit_miss = 1'b1; hit_miss_set = 4'b0100; ages = 8'b00_01_11_10;
      tick();
      hit_miss = 1'b0; hit_miss_set = '0; ages = 8'h00;
      #1;
      vec_cnt++;
      if ({reset_age, increment_age} !== 8'b0100_1000) begin err_cnt++; $display("FAIL hit_ages got %b exp 01001000", {reset_age, increment_age}); end
      vec_cnt++;
      if ({resp_valid, try_read, mem_req} !== 3'b100) begin err_cnt++; $display("FAIL hit_resp got %b exp 100", {resp_valid, try_read, mem_req}); end
      tick();
      vec_cnt++;
      if ({req_ready, resp_valid, reset_age, increment_age} !== 10'b10_0000_0000) begin
         err_cnt++; $display("FAIL hit_idle got %b exp 1000000000", {req_ready, resp_valid, reset_age, increment_age});
      end
   endtask

   task automatic test_clean_miss();
      issue(1'b0, 32'h0000_5678, 8'h00);
      hit_miss = 1'b0; ages = 8'b00_01_11_10; dirty = 4'b0000;
      mem_ack = 1'b1;   // ack in LOOKUP is ignored
      tick();
      mem_ack = 1'b0; ages = 8'h00;
      for (int c = 0; c < 3; c++) begin
         vec_cnt++;
         if ({mem_req, mem_we, mem_way, try_read, resp_valid} !== 8'b10_0010_00) begin
            err_cnt++; $display("FAIL miss_fill_c%0d got %b exp 10001000", c, {mem_req, mem_we, mem_way, try_read, resp_valid});
         end
         if (c == 2) mem_ack = 1'b1;
         tick();
      end
      mem_ack = 1'b0;
      vec_cnt++;
      if ({try_read, try_write, mem_req, reset_age} !== 7'b100_0000) begin err_cnt++; $display("FAIL miss_replay got %b exp 1000000", {try_read, try_write, mem_req, reset_age}); end
      tick();
      vec_cnt++;
      if ({resp_valid, reset_age, increment_age} !== 9'b1_0010_1101) begin err_cnt++; $display("FAIL miss_update got %b exp 100101101", {resp_valid, reset_age, increment_age}); end
      tick();
      vec_cnt++;
      if ({req_ready, increment_age} !== 5'b1_0000) begin err_cnt++; $display("FAIL miss_idle got %b exp 10000", {req_ready, increment_age}); end
   endtask

   task automatic test_tie();
      issue(1'b0, 32'h0000_0040, 8'h00);
      hit_miss = 1'b0; ages = 8'hFF; dirty = 4'b0000;
      tick();
      ages = 8'h1B;
      vec_cnt++;
      if ({mem_req, mem_we, mem_way} !== 6'b10_0001) begin err_cnt++; $display("FAIL tie_way got %b exp 100001", {mem_req, mem_we, mem_way}); end
      mem_ack = 1'b1;   // ack in the first request cycle
      tick();
      mem_ack = 1'b0;
      vec_cnt++;
      if ({try_read, mem_req} !== 2'b10) begin err_cnt++; $display("FAIL tie_replay got %b exp 10", {try_read, mem_req}); end
      tick();
      vec_cnt++;
      if ({resp_valid, reset_age, increment_age} !== 9'b1_0001_0000) begin err_cnt++; $display("FAIL tie_update got %b exp 100010000", {resp_valid, reset_age, increment_age}); end
      tick();
      ages = 8'h00;
   endtask

   task automatic test_write_miss();
      issue(1'b1, 32'h0000_9ABC, 8'hA5);
      vec_cnt++;
      if ({try_read, try_write} !== 2'b01) begin err_cnt++; $display("FAIL wm_lookup got %b exp 01", {try_read, try_write}); end
      hit_miss = 1'b0; ages = 8'b00_01_11_10; dirty = 4'b0010;
      tick();
      ages = 8'h00; dirty = 4'b0000;
`ifdef CACHE_WB_EN
      vec_cnt++;
      if ({mem_req, mem_we, mem_way} !== 6'b11_0010) begin err_cnt++; $display("FAIL wm_evict got %b exp 110010", {mem_req, mem_we, mem_way}); end
      tick();
      vec_cnt++;
      if ({mem_req, mem_we, mem_way} !== 6'b11_0010) begin err_cnt++; $display("FAIL wm_evict_hold got %b exp 110010", {mem_req, mem_we, mem_way}); end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
`endif
      vec_cnt++;
      if ({mem_req, mem_we, mem_way} !== 6'b10_0010) begin err_cnt++; $display("FAIL wm_fill got %b exp 100010", {mem_req, mem_we, mem_way}); end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      vec_cnt++;
      if ({try_read, try_write, write_data} !== 10'b01_1010_0101) begin err_cnt++; $display("FAIL wm_replay got %b exp 0110100101", {try_read, try_write, write_data}); end
      tick();
      vec_cnt++;
      if ({reset_age, increment_age} !== 8'b0010_1101) begin err_cnt++; $display("FAIL wm_update got %b exp 00101101", {reset_age, increment_age}); end
`ifdef CACHE_WB_EN
      vec_cnt++;
      if (resp_valid !== 1'b1) begin err_cnt++; $display("FAIL wm_resp got %b exp 1", resp_valid); end
      tick();
`else
      vec_cnt++;
      if (resp_valid !== 1'b0) begin err_cnt++; $display("FAIL wm_resp_early got %b exp 0", resp_valid); end
      tick();
      vec_cnt++;
      if ({mem_req, mem_we, mem_way, resp_valid} !== 7'b11_0010_0) begin err_cnt++; $display("FAIL wm_wt got %b exp 1100100", {mem_req, mem_we, mem_way, resp_valid}); end
      mem_ack = 1'b1;
      #1;
      vec_cnt++;
      if (resp_valid !== 1'b1) begin err_cnt++; $display("FAIL wm_wt_resp got %b exp 1", resp_valid); end
      tick();
      mem_ack = 1'b0;
`endif
      vec_cnt++;
      if ({req_ready, mem_req} !== 2'b10) begin err_cnt++; $display("FAIL wm_idle got %b exp 10", {req_ready, mem_req}); end
   endtask

   task automatic test_write_hit_wt();
      issue(1'b1, 32'h0000_7777, 8'h3C);
      hit_miss = 1'b1; hit_miss_set = 4'b1000; ages = 8'b00_01_11_10;
      tick();
      hit_miss = 1'b0; hit_miss_set = '0; ages = 8'h00;
      vec_cnt++;
      if ({reset_age, increment_age} !== 8'b1000_0000) begin err_cnt++; $display("FAIL wh_update got %b exp 10000000", {reset_age, increment_age}); end
`ifdef CACHE_WB_EN
      vec_cnt++;
      if (resp_valid !== 1'b1) begin err_cnt++; $display("FAIL wh_resp got %b exp 1", resp_valid); end
      tick();
`else
      vec_cnt++;
      if ({resp_valid, mem_req} !== 2'b00) begin err_cnt++; $display("FAIL wh_update_resp got %b exp 00", {resp_valid, mem_req}); end
      tick();
      req_valid = 1'b1; req_opcode = 1'b0; req_addr = 32'h0000_0BAD;
      #1;
      for (int c = 0; c < 2; c++) begin
         vec_cnt++;
         if ({mem_req, mem_we, mem_way, resp_valid, req_ready} !== 8'b11_1000_00) begin
            err_cnt++; $display("FAIL wh_wt_c%0d got %b exp 11100000", c, {mem_req, mem_we, mem_way, resp_valid, req_ready});
         end
         tick();
      end
      vec_cnt++;
      if (address_word !== 32'h0000_7777) begin err_cnt++; $display("FAIL wh_addr_hold got %h exp 00007777", address_word); end
      mem_ack = 1'b1;
      #1;
      vec_cnt++;
      if (resp_valid !== 1'b1) begin err_cnt++; $display("FAIL wh_wt_resp got %b exp 1", resp_valid); end
      tick();
      mem_ack = 1'b0; req_valid = 1'b0;
`endif
      vec_cnt++;
      if ({req_ready, resp_valid, mem_req} !== 3'b100) begin err_cnt++; $display("FAIL wh_idle got %b exp 100", {req_ready, resp_valid, mem_req}); end
      vec_cnt++;
      if (address_word !== 32'h0000_7777) begin err_cnt++; $display("FAIL wh_no_accept got %h exp 00007777", address_word); end
   endtask

   task automatic test_reset_mid_fill();
      issue(1'b0, 32'hDEAD_0000, 8'h00);
      hit_miss = 1'b0; ages = 8'b00_01_11_10; dirty = 4'b0000;
      tick();
      vec_cnt++;
      if (mem_req !== 1'b1) begin err_cnt++; $display("FAIL rmf_fill got %b exp 1", mem_req); end
      rst_b = 1'b0;
      #1;
      vec_cnt++;
      if ({mem_req, mem_way, try_read, resp_valid} !== 7'b0) begin err_cnt++; $display("FAIL rmf_drop got %b exp 0", {mem_req, mem_way, try_read, resp_valid}); end
      vec_cnt++;
      if ({address_word, reset_age, increment_age} !== 40'h0) begin err_cnt++; $display("FAIL rmf_regs got %h exp 0", {address_word, reset_age, increment_age}); end
      @(negedge clk); rst_b = 1'b1;
      tick();
      vec_cnt++;
      if ({req_ready, mem_req} !== 2'b10) begin err_cnt++; $display("FAIL rmf_release got %b exp 10", {req_ready, mem_req}); end
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_clean_miss();
      test_tie();
      test_write_miss();
      test_write_hit_wt();
      test_reset_mid_fill();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/cache_lru_ctrl.md
# cache_lru_ctrl

Parametrised successor of the cache control unit: sequences one read/write request at a time through lookup, optional dirty-victim write-back, line fill, replay and LRU age update for an N-way set-associative cache. Sits between the CPU-side request port and the tag/data array plus LRU age registers. It also drives the memory-side request/acknowledge handshake, and adds request flow control and miss handling that the 4-way fixed control unit does not have.

## Interface
- WAYS, 4, associativity; power of two, 2..16
- AGE_W, $clog2(WAYS), bits per LRU age
- ADDR_W, 32, request address width
- DATA_W, 8, write data width
- clk  in  1  clock, all state updates on rising edge
- rst_b  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  block idle, request accepted when req_valid & req_ready
- req_opcode  in  1  0 = read, 1 = write
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  one-cycle pulse, request complete
- hit_miss  in  1  array lookup result, 1 = hit
- hit_miss_set  in  WAYS  one-hot hitting way
- ages  in  WAYS*AGE_W  way i age at [i*AGE_W +: AGE_W]; 0 = most recent
- dirty  in  WAYS  per-way dirty flags of the addressed set
- address_word  out  ADDR_W  captured request address
- write_data  out  DATA_W  captured write data
- try_read  out  1  array read strobe
- try_write  out  1  array write strobe
- reset_age  out  WAYS  clear age of marked way
- increment_age  out  WAYS  increment ages of marked ways
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write-back, 0 = fill
- mem_way  out  WAYS  one-hot victim way for transfer
- mem_ack  in  1  memory transfer complete

## Operation
- States: IDLE, LOOKUP, EVICT, FILL, REPLAY, UPDATE, WT.
- IDLE: req_ready=1. On handshake, capture opcode/addr/wdata -> LOOKUP.
- LOOKUP: try_read=~op, try_write=op; sample hit_miss, hit_miss_set, ages, dirty at cycle end. Hit -> UPDATE with way = lowest set bit of hit_miss_set. Miss -> victim = lowest-index way holding the maximum age; -> EVICT if dirty[victim] (write-back build only), else FILL.
- EVICT: mem_req=1, mem_we=1, mem_way=victim until mem_ack -> FILL.
- FILL: mem_req=1, mem_we=0, mem_way=victim until mem_ack -> REPLAY.
- REPLAY: re-issue try_read/try_write for one cycle (write-allocate) -> UPDATE with way = victim.
- UPDATE: reset_age[way]=1; increment_age[i]=1 for every i with ages[i] < ages[way] (unsigned, sampled ages). Then resp_valid=1 -> IDLE, or -> WT for write-through writes.
- WT: mem_req=1, mem_we=1, mem_way=way until mem_ack; resp_valid=1 in ack cycle -> IDLE.
- mem_ack outside EVICT/FILL/WT ignored; ack in the first request cycle is accepted.
- req_valid while not IDLE is not accepted; captured fields stay stable until IDLE.

## Timing
- Reset: state IDLE; address_word, write_data, all strobes, reset_age, increment_age, mem_*, resp_valid = 0; req_ready=1.
- Reset mid-transfer aborts immediately; mem_req drops asynchronously.
- Strobes are Moore decode of state plus captured way/victim registers.
- Read hit latency: accept edge -> LOOKUP (1) -> UPDATE with resp_valid (2).
- Clean miss: 2 + fill cycles (until ack) + REPLAY + UPDATE.
- Age updates last exactly one cycle; never asserted outside UPDATE.

## Configuration
- CACHE_WB_EN defined: write-back; dirty victims evicted before fill; WT state unreachable; write hits complete in UPDATE.
- Undefined: write-through; dirty ignored, EVICT unreachable; every write passes UPDATE -> WT and waits for mem_ack before resp_valid.

## Test plan
- Reset: rst_b=0 mid-FILL -> mem_req=0 immediately, all outputs 0, req_ready=1 after release.
- Read hit, WAYS=4: addr 0x00001234, hit_miss_set=4'b0100, ages=8'b00_01_11_10 -> try_read cycle 1, UPDATE cycle 2 reset_age=4'b0100, increment_age=4'b1000, resp_valid=1.
- Clean read miss, same ages, dirty=0, mem_ack 3 cycles after mem_req -> FILL mem_way=4'b0010, REPLAY try_read, reset_age=4'b0010, increment_age=4'b1101.
- CACHE_WB_EN, write miss, dirty=4'b0010 -> EVICT mem_we=1 until ack, FILL mem_we=0, REPLAY try_write, write_data=captured value.
- Tie: ages=8'hFF miss -> victim way0, mem_way=4'b0001, increment_age=4'b0000.
- No CACHE_WB_EN, write hit way3 -> UPDATE then WT mem_we=1, mem_way=4'b1000; resp_valid only in ack cycle; req_valid during WT not accepted.
